// File: rtl/hnet_chk_sink_pkg.sv
// hnet_chk_sink shared defs: hglobal macros, state codes, helpers.
// HNET_CHK_SYNC_EN (optional) adds 2-flop req synchronizers.
`ifndef HGLOBAL_V
`define HGLOBAL_V
`define ON 1'b1
`define OFF 1'b0
`define ADDRESS_SIZE 8
`define DATA_SIZE 16
`define BIT_TOGGLE(b) (~(b))
`endif

`ifndef HNET_CHK_IDLE
`define HNET_CHK_IDLE 2'd0
`define HNET_CHK_ACK 2'd1
`define HNET_CHK_WAIT_LOW 2'd2
`endif

package hnet_chk_sink_pkg;

  localparam logic [1:0] ST_IDLE = `HNET_CHK_IDLE;
  localparam logic [1:0] ST_ACK  = `HNET_CHK_ACK;
  localparam logic [1:0] ST_WAIT = `HNET_CHK_WAIT_LOW;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hnet_chk_chan.sv
// One hnet_chk_sink channel: 4-phase FSM, checker, counter.
// HNET_CHK_SYNC_EN selects a 2-flop synchronizer on i_req.
module hnet_chk_chan
  import hnet_chk_sink_pkg::*;
#(
  parameter int CH      = 0,
  parameter int ADDR_SZ = `ADDRESS_SIZE,
  parameter int DATA_SZ = `DATA_SIZE,
  parameter int CNT_SZ  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req,
  input  logic [ADDR_SZ-1:0] i_addr,
  input  logic [DATA_SZ-1:0] i_dat,
  output logic               o_ack,
  output logic [DATA_SZ-1:0] o_dat,
  output logic [CNT_SZ-1:0]  o_cnt,
  output logic               o_err
);

  localparam logic [ADDR_SZ-1:0] MY_ADDR = ADDR_SZ'(CH);

  logic               req;
  logic [1:0]         state;
  logic [ADDR_SZ-1:0] lat_addr;
  logic [DATA_SZ-1:0] lat_dat;
  logic [DATA_SZ-1:0] exp_dat;
  logic               chk;

`ifdef HNET_CHK_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) sync <= 2'b00;
    else       sync <= {sync[0], i_req};
  end

  assign req = sync[1];
`else
  assign req = i_req;
`endif

  // check runs the cycle after the latch so o_err lags by one
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      o_ack    <= `OFF;
      lat_addr <= '0;
      lat_dat  <= '0;
      exp_dat  <= DATA_SZ'(1);
      o_cnt    <= '0;
      chk      <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      chk <= 1'b0;
      if (chk) begin
        if ((lat_addr != MY_ADDR) || (lat_dat != exp_dat))
          o_err <= 1'b1;
        exp_dat <= lat_dat + 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            lat_addr <= i_addr;
            lat_dat  <= i_dat;
            chk      <= 1'b1;
            o_ack    <= `ON;
            state    <= ST_ACK;
            if (o_cnt != '1)
              o_cnt <= o_cnt + 1'b1;
          end
        end
        ST_ACK: begin
          if (!req) begin
            o_ack <= `OFF;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_dat = lat_dat;

endmodule

// File: rtl/hnet_chk_sink.sv
// hnet_chk_sink: NUM_CH checked 4-phase sinks plus snapshot readback.
// HNET_CHK_SYNC_EN adds 2-cycle req synchronization per channel.
module hnet_chk_sink
  import hnet_chk_sink_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int ADDR_SZ = `ADDRESS_SIZE,
  parameter int DATA_SZ = `DATA_SIZE,
  parameter int CNT_SZ  = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_CH-1:0]           i_req,
  input  logic [NUM_CH*ADDR_SZ-1:0]   i_addr,
  input  logic [NUM_CH*DATA_SZ-1:0]   i_dat,
  output logic [NUM_CH-1:0]           o_ack,
  input  logic [sel_w(NUM_CH)-1:0]    i_sel,
  input  logic                        i_snap,
  output logic [DATA_SZ-1:0]          o_dat,
  output logic [CNT_SZ-1:0]           o_cnt,
  output logic [NUM_CH-1:0]           o_err,
  output logic                        o_err_any
);

  logic [DATA_SZ-1:0] ch_dat [NUM_CH];
  logic [CNT_SZ-1:0]  ch_cnt [NUM_CH];
  logic [DATA_SZ-1:0] sel_dat;
  logic [CNT_SZ-1:0]  sel_cnt;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    hnet_chk_chan #(
      .CH      (k),
      .ADDR_SZ (ADDR_SZ),
      .DATA_SZ (DATA_SZ),
      .CNT_SZ  (CNT_SZ)
    ) u_chan (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_req  (i_req[k]),
      .i_addr (i_addr[k*ADDR_SZ +: ADDR_SZ]),
      .i_dat  (i_dat[k*DATA_SZ +: DATA_SZ]),
      .o_ack  (o_ack[k]),
      .o_dat  (ch_dat[k]),
      .o_cnt  (ch_cnt[k]),
      .o_err  (o_err[k])
    );
  end

  // unmatched selects fall through to zero
  always_comb begin
    sel_dat = '0;
    sel_cnt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(i_sel) == k) begin
        sel_dat = ch_dat[k];
        sel_cnt = ch_cnt[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dat <= '0;
      o_cnt <= '0;
    end else if (i_snap) begin
      o_dat <= sel_dat;
      o_cnt <= sel_cnt;
    end
  end

  assign o_err_any = |o_err;

endmodule
